// File: rtl/gpr_writeback_sink.sv
// rtl/gpr_writeback_sink.sv - writeback sink: 2-entry packet FIFO feeding the GPR write port and scoreboard release
module gpr_writeback_sink #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = 64,
  localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NR_BITS    = $clog2(NUM_REGS),
  localparam int DW         = NUM_THREADS * XLEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_valid,
  output logic                        wb_ready,
  input  logic [NW_WIDTH-1:0]         wb_wid,
  input  logic [XLEN-1:0]             wb_PC,
  input  logic [NUM_THREADS-1:0]      wb_tmask,
  input  logic [NR_BITS-1:0]          wb_rd,
  input  logic [DW-1:0]               wb_data,
  input  logic                        wb_eop,
  output logic                        gpr_wvalid,
  input  logic                        gpr_wr_ready,
  output logic [NW_WIDTH+NR_BITS-1:0] gpr_waddr,
  output logic [NUM_THREADS-1:0]      gpr_wmask,
  output logic [DW-1:0]               gpr_wdata,
  output logic                        sb_release_valid,
  output logic [NW_WIDTH-1:0]         sb_release_wid,
  output logic [NR_BITS-1:0]          sb_release_rd,
  output logic [31:0]                 perf_wb_count,
  output logic [XLEN-1:0]             sim_last_pc
);

  // Packet storage, two slots addressed by the read/write pointers.
  logic [NW_WIDTH-1:0]    ent_wid_q   [2];
  logic [XLEN-1:0]        ent_pc_q    [2];
  logic [NUM_THREADS-1:0] ent_tmask_q [2];
  logic [NR_BITS-1:0]     ent_rd_q    [2];
  logic [DW-1:0]          ent_data_q  [2];
  logic                   ent_eop_q   [2];

  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q,  count_d;

  logic                rel_valid_q, rel_valid_d;
  logic [NW_WIDTH-1:0] rel_wid_q,   rel_wid_d;
  logic [NR_BITS-1:0]  rel_rd_q,    rel_rd_d;
  logic [31:0]         perf_q,      perf_d;
  logic [XLEN-1:0]     last_pc_q,   last_pc_d;

  logic                   push;
  logic                   head_valid;
  logic                   real_write;
  logic                   commit;
  logic                   commit_real;
  logic [NW_WIDTH-1:0]    head_wid;
  logic [XLEN-1:0]        head_pc;
  logic [NUM_THREADS-1:0] head_tmask;
  logic [NR_BITS-1:0]     head_rd;
  logic [DW-1:0]          head_data;
  logic                   head_eop;

  // Ready is purely registered occupancy, so write-port back-pressure never
  // reaches the arbiter combinationally. Held low while reset is asserted.
  assign wb_ready = (count_q != 2'd2) & reset;
  assign push     = wb_valid & wb_ready;

  // The head is masked during reset so nothing is presented or committed
  // in a cycle whose state is about to be discarded.
  assign head_valid = (count_q != 2'd0) & reset;
  assign head_wid   = ent_wid_q[rd_ptr_q];
  assign head_pc    = ent_pc_q[rd_ptr_q];
  assign head_tmask = ent_tmask_q[rd_ptr_q];
  assign head_rd    = ent_rd_q[rd_ptr_q];
  assign head_data  = ent_data_q[rd_ptr_q];
  assign head_eop   = ent_eop_q[rd_ptr_q];

  // Writes to x0 or with no active lanes never touch the register file;
  // they drain on their own without waiting for the write port.
  assign real_write  = head_valid & (head_rd != '0) & (head_tmask != '0);
  assign commit_real = real_write & gpr_wr_ready;
  assign commit      = head_valid & (~real_write | gpr_wr_ready);

  // GPR port is driven from the head entry and forced to zero when idle.
  always_comb begin
    gpr_wvalid = real_write;
    gpr_waddr  = '0;
    gpr_wmask  = '0;
    gpr_wdata  = '0;
    if (real_write) begin
      gpr_waddr = {head_wid, head_rd};
      gpr_wmask = head_tmask;
      gpr_wdata = head_data;
    end
  end

  // Capture an accepted packet into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_wid_q[wr_ptr_q]   <= wb_wid;
      ent_pc_q[wr_ptr_q]    <= wb_PC;
      ent_tmask_q[wr_ptr_q] <= wb_tmask;
      ent_rd_q[wr_ptr_q]    <= wb_rd;
      ent_data_q[wr_ptr_q]  <= wb_data;
      ent_eop_q[wr_ptr_q]   <= wb_eop;
    end
  end

  // Pointer and occupancy update; push and pop together leave count unchanged.
  always_comb begin
    rd_ptr_d = rd_ptr_q ^ commit;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q;
    case ({push, commit})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Release, performance and last-PC bookkeeping for the committing head.
  always_comb begin
    rel_valid_d = commit & head_eop;
    rel_wid_d   = '0;
    rel_rd_d    = '0;
    if (commit & head_eop) begin
      rel_wid_d = head_wid;
      rel_rd_d  = head_rd;
    end
    perf_d    = commit_real ? perf_q + 32'd1 : perf_q;
    last_pc_d = commit ? head_pc : last_pc_q;
  end

  // Control and status registers; reset discards buffered packets silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      rel_valid_q <= 1'b0;
      rel_wid_q   <= '0;
      rel_rd_q    <= '0;
      perf_q      <= '0;
      last_pc_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rel_valid_q <= rel_valid_d;
      rel_wid_q   <= rel_wid_d;
      rel_rd_q    <= rel_rd_d;
      perf_q      <= perf_d;
      last_pc_q   <= last_pc_d;
    end
  end

  assign sb_release_valid = rel_valid_q;
  assign sb_release_wid   = rel_wid_q;
  assign sb_release_rd    = rel_rd_q;
  assign perf_wb_count    = perf_q;
  assign sim_last_pc      = last_pc_q;

endmodule

// File: tb/tb_gpr_writeback_sink.sv
// tb/tb_gpr_writeback_sink.sv - directed and randomized bench with a packet-queue reference model
module tb_gpr_writeback_sink;

  typedef struct packed {
    logic [1:0]   wid;
    logic [31:0]  pc;
    logic [3:0]   tmask;
    logic [5:0]   rd;
    logic [127:0] data;
    logic         eop;
  } pkt_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_valid;
  logic         wb_ready;
  logic [1:0]   wb_wid;
  logic [31:0]  wb_PC;
  logic [3:0]   wb_tmask;
  logic [5:0]   wb_rd;
  logic [127:0] wb_data;
  logic         wb_eop;
  logic         gpr_wvalid;
  logic         gpr_wr_ready;
  logic [7:0]   gpr_waddr;
  logic [3:0]   gpr_wmask;
  logic [127:0] gpr_wdata;
  logic         sb_release_valid;
  logic [1:0]   sb_release_wid;
  logic [5:0]   sb_release_rd;
  logic [31:0]  perf_wb_count;
  logic [31:0]  sim_last_pc;

  gpr_writeback_sink dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid), .wb_PC(wb_PC),
    .wb_tmask(wb_tmask), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
    .gpr_wvalid(gpr_wvalid), .gpr_wr_ready(gpr_wr_ready), .gpr_waddr(gpr_waddr),
    .gpr_wmask(gpr_wmask), .gpr_wdata(gpr_wdata),
    .sb_release_valid(sb_release_valid), .sb_release_wid(sb_release_wid),
    .sb_release_rd(sb_release_rd), .perf_wb_count(perf_wb_count),
    .sim_last_pc(sim_last_pc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rel_seen = 0;
  int wv_seen  = 0;

  // Reference model: packets in flight, pending release and counters.
  pkt_t        mq[$];
  logic        m_rel_v   = 1'b0;
  logic [1:0]  m_rel_wid = '0;
  logic [5:0]  m_rel_rd  = '0;
  logic [31:0] m_perf    = '0;
  logic [31:0] m_pc      = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [1:0] wid, input logic [31:0] pc, input logic [3:0] tm,
                              input logic [5:0] rd, input logic [127:0] data, input logic eop);
    pkt_t p;
    p.wid = wid; p.pc = pc; p.tmask = tm; p.rd = rd; p.data = data; p.eop = eop;
    return p;
  endfunction

  function automatic pkt_t rnd_pkt();
    pkt_t p;
    p.wid   = 2'($urandom_range(0, 3));
    p.pc    = $urandom;
    p.tmask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    p.rd    = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    p.data  = {$urandom, $urandom, $urandom, $urandom};
    p.eop   = 1'($urandom_range(0, 1));
    return p;
  endfunction

  // One clock cycle: drive at negedge, compare against the model, then
  // advance the model on the rising edge.
  task automatic step(input logic v, input pkt_t p, input logic rdy, input logic rst);
    logic exp_ready, exp_wv, head_ok, cm, fire;
    pkt_t h;
    @(negedge clk);
    reset = rst; wb_valid = v; gpr_wr_ready = rdy;
    wb_wid = p.wid; wb_PC = p.pc; wb_tmask = p.tmask; wb_rd = p.rd; wb_data = p.data; wb_eop = p.eop;
    #1;
    h         = (mq.size() > 0) ? mq[0] : '0;
    head_ok   = rst && (mq.size() > 0);
    exp_ready = rst && (mq.size() < 2);
    exp_wv    = head_ok && (h.rd != 0) && (h.tmask != 0);
    chk("wb_ready", wb_ready, exp_ready);
    chk("gpr_wvalid", gpr_wvalid, exp_wv);
    chk("gpr_waddr", gpr_waddr, exp_wv ? {h.wid, h.rd} : 8'h0);
    chk("gpr_wmask", gpr_wmask, exp_wv ? h.tmask : 4'h0);
    chk("gpr_wdata", gpr_wdata, exp_wv ? h.data : 128'h0);
    chk("rel_valid", sb_release_valid, m_rel_v);
    chk("rel_wid", sb_release_wid, m_rel_wid);
    chk("rel_rd", sb_release_rd, m_rel_rd);
    chk("perf", perf_wb_count, m_perf);
    chk("last_pc", sim_last_pc, m_pc);
    if (sb_release_valid === 1'b1) rel_seen++;
    if (gpr_wvalid === 1'b1) wv_seen++;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_rel_v = 0; m_rel_wid = 0; m_rel_rd = 0; m_perf = 0; m_pc = 0;
    end else begin
      cm   = head_ok && (!exp_wv || rdy);
      fire = v && exp_ready;
      m_rel_v   = cm && h.eop;
      m_rel_wid = (cm && h.eop) ? h.wid : 2'd0;
      m_rel_rd  = (cm && h.eop) ? h.rd : 6'd0;
      if (cm) begin
        if (exp_wv) m_perf = m_perf + 32'd1;
        m_pc = h.pc;
        void'(mq.pop_front());
      end
      if (fire) mq.push_back(p);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b1);
  endtask

  initial begin
    int r0, w0;
    logic [31:0] p0;
    pkt_t a, b, c;
    reset = 1'b0; wb_valid = 1'b0; gpr_wr_ready = 1'b0;
    wb_wid = '0; wb_PC = '0; wb_tmask = '0; wb_rd = '0; wb_data = '0; wb_eop = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then first cycle out of reset.
    step(1'b0, '0, 1'b0, 1'b0);
    idle(1, 1'b1);

    // Single packet with immediate acceptance.
    r0 = rel_seen;
    a = mk(2'd1, 32'h8000_0010, 4'b1011, 6'd5, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1);
    step(1'b1, a, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    #1;
    chk("single_perf", perf_wb_count, 32'd1);
    chk("single_pc", sim_last_pc, 32'h8000_0010);
    chk("single_rel", sb_release_valid, 1'b1);
    chk("single_rel_rd", sb_release_rd, 6'd5);
    idle(2, 1'b1);
    chk("single_rel_cnt", rel_seen - r0, 32'd1);

    // Back-pressure: three packets offered, two accepted during the stall.
    r0 = rel_seen; p0 = m_perf;
    a = mk(2'd0, 32'h100, 4'hF, 6'd1, {4{32'h1111_1111}}, 1'b1);
    b = mk(2'd3, 32'h104, 4'h3, 6'd2, {4{32'h2222_2222}}, 1'b1);
    c = mk(2'd2, 32'h108, 4'h8, 6'd3, {4{32'h3333_3333}}, 1'b1);
    step(1'b1, a, 1'b0, 1'b1);
    step(1'b1, b, 1'b0, 1'b1);
    step(1'b1, c, 1'b0, 1'b1);
    step(1'b1, c, 1'b0, 1'b1);
    step(1'b1, c, 1'b1, 1'b1);
    step(1'b1, c, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("bp_rel_cnt", rel_seen - r0, 32'd3);
    chk("bp_perf", m_perf - p0, 32'd3);
    chk("bp_last_pc", sim_last_pc, 32'h108);

    // x0 destination and empty lane mask: null writes that still release.
    r0 = rel_seen; w0 = wv_seen; p0 = perf_wb_count;
    step(1'b1, mk(2'd1, 32'h200, 4'hF, 6'd0, 128'h5, 1'b1), 1'b1, 1'b1);
    step(1'b1, mk(2'd1, 32'h204, 4'h0, 6'd7, 128'h6, 1'b1), 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("null_wv_cnt", wv_seen - w0, 32'd0);
    chk("null_rel_cnt", rel_seen - r0, 32'd2);
    chk("null_perf", perf_wb_count, p0);
    chk("null_pc", sim_last_pc, 32'h204);

    // Multi-packet instruction: only the eop packet releases.
    r0 = rel_seen; p0 = perf_wb_count;
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(2'd2, 32'h300, 4'hF, 6'd9, {4{32'(i)}}, i == 2), 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("multi_rel_cnt", rel_seen - r0, 32'd1);
    chk("multi_perf", perf_wb_count - p0, 32'd3);

    // Reset while two packets are stalled in the FIFO.
    r0 = rel_seen;
    step(1'b1, a, 1'b0, 1'b1);
    step(1'b1, b, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("rst_rel_cnt", rel_seen - r0, 32'd0);
    chk("rst_perf", perf_wb_count, 32'd0);
    chk("rst_ready", wb_ready, 1'b1);

    // Performance counter wrap.
    @(negedge clk);
    force dut.perf_q = 32'hFFFF_FFFF;
    m_perf = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.perf_q;
    step(1'b1, mk(2'd0, 32'h400, 4'h1, 6'd4, 128'h7, 1'b0), 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("wrap_perf", perf_wb_count, 32'd0);

    // Randomized traffic with random write-port back-pressure and resets.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rnd_pkt(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 99) != 0));
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
